// File: rtl/dcache_l1.sv
// dcache_l1 -- direct-mapped, write-through, no-write-allocate L1 data cache.
//
// Loads that hit return data in the same cycle. Loads that miss refill the
// whole line from memory one word at a time, then release the CPU for one
// cycle in DONE. Stores always go to memory, one word per store. A store
// that hits also updates the enabled bytes of the cached word. A store that
// misses does not allocate a line.
//
// Ports:
//   clock, reset           sole clock; synchronous active-high reset
//   cpu_rd / cpu_wr        load / store request (both high = store)
//   cpu_addr               byte address, bits [1:0] ignored
//   cpu_wdata, cpu_be      store data and byte enables
//   cpu_rdata, cpu_stall   load data; CPU must hold its request while stalled
//   inv_all                invalidate every line (IDLE only, with no request)
//   mem_req, mem_we        single-word memory request, 1 = write
//   mem_addr               word-aligned byte address
//   mem_wdata, mem_be      write data and byte enables
//   mem_ready, mem_rdata   word accepted / returned this cycle
//   hit_count, miss_count  saturating statistics (only with DCACHE_STATS_EN)
//
// Build option: define DCACHE_STATS_EN to add the hit/miss statistics outputs.
//
// state  | meaning
// IDLE   | serve hits, accept a miss or store, handle inv_all
// REFILL | read the line from memory word by word
// WRITE  | write one word through to memory
// DONE   | release the CPU for one cycle

module dcache_l1 #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              inv_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  // The word counter needs at least one bit, even for one-word lines.
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int IDX_LSB  = 2 + OFF_BITS;
  localparam int TAG_LSB  = IDX_LSB + IDX_W;
  localparam int TAG_W    = ADDR_W - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [OFF_W-1:0]  r_cnt;
  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag  [NUM_SETS];
  logic [31:0]       r_data [NUM_SETS][LINE_WORDS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [OFF_W-1:0]  w_off;
  logic [ADDR_W-1:0] w_line_base;
  logic              w_hit;
  logic              w_refill_start;
  logic              w_fill_we;
  logic              w_wt_we;
  logic              w_inv;
  logic              w_unused;

  assign w_idx       = cpu_addr[TAG_LSB-1:IDX_LSB];
  assign w_tag       = cpu_addr[ADDR_W-1:TAG_LSB];
  assign w_line_base = {cpu_addr[ADDR_W-1:IDX_LSB], IDX_LSB'(0)};
  assign w_unused    = ^cpu_addr[1:0];

  generate
    if (OFF_BITS > 0) begin : g_off
      assign w_off = cpu_addr[IDX_LSB-1:2];
    end else begin : g_no_off
      assign w_off = '0;
    end
  endgenerate

  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // The line array feeds the CPU unconditionally; the data only matters on
  // an IDLE hit or in DONE after a load, when the address is still held.
  assign cpu_rdata = r_data[w_idx][w_off];

  always_comb begin
    w_next         = r_state;
    cpu_stall      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_be         = '0;
    w_refill_start = 1'b0;
    w_fill_we      = 1'b0;
    w_wt_we        = 1'b0;
    w_inv          = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_wr) begin
          cpu_stall = 1'b1;
          w_next    = WRITE;
        end else if (cpu_rd) begin
          if (!w_hit) begin
            cpu_stall      = 1'b1;
            w_next         = REFILL;
            w_refill_start = 1'b1;
          end
        end else if (inv_all) begin
          w_inv = 1'b1;
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = w_line_base + (ADDR_W'(r_cnt) << 2);
        if (mem_ready) begin
          w_fill_we = 1'b1;
          if (r_cnt == LAST_WORD) w_next = DONE;
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        mem_be    = cpu_be;
        if (mem_ready) begin
          w_wt_we = w_hit;
          w_next  = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_tag[s] <= '0;
        for (int w = 0; w < LINE_WORDS; w++) r_data[s][w] <= '0;
      end
    end else begin
      r_state <= w_next;
      // The line is invalid for the whole refill so an abandoned refill can
      // never leave a half-written line looking valid.
      if (w_refill_start) begin
        r_cnt          <= '0;
        r_valid[w_idx] <= 1'b0;
      end
      if (w_fill_we) begin
        r_data[w_idx][r_cnt] <= mem_rdata;
        r_cnt                <= r_cnt + 1'b1;
        if (r_cnt == LAST_WORD) begin
          r_tag[w_idx]   <= w_tag;
          r_valid[w_idx] <= 1'b1;
        end
      end
      if (w_wt_we) begin
        for (int b = 0; b < 4; b++) begin
          if (cpu_be[b]) r_data[w_idx][w_off][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
      if (w_inv) r_valid <= '0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;
  logic        w_hit_evt;
  logic        w_miss_evt;

  assign w_hit_evt  = ((r_state == IDLE) && !cpu_wr && cpu_rd && w_hit) || w_wt_we;
  assign w_miss_evt = w_refill_start || ((r_state == WRITE) && mem_ready && !w_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_evt && (r_hit_count != 32'hFFFF_FFFF)) r_hit_count <= r_hit_count + 1'b1;
      if (w_miss_evt && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_l1.sv
module tb_dcache_l1;
  localparam int LW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        inv_all;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_l1 #(.ADDR_W(32), .LINE_WORDS(LW), .NUM_SETS(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .inv_all(inv_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: 1024 words, word-addressed by addr[11:2].
  logic [31:0] tb_mem [0:1023];
  logic        ready_allow = 1'b1;
  bit          gap_mode = 1'b0;

  assign mem_ready = mem_req & ready_allow;
  assign mem_rdata = mem_ready ? tb_mem[mem_addr[11:2]] : 32'h0;

  always @(negedge clock) ready_allow <= gap_mode ? ~ready_allow : 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  txn_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;

  // Scoreboard for memory traffic: each word about to be accepted at the
  // coming posedge is compared with the oldest expected transaction.
  always @(negedge clock) begin
    #2;
    if (mem_req && mem_ready && !reset) begin
      acc_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mem_txn: got unexpected we=%0b addr=%h, required no transaction", mem_we, mem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_we !== mon_e.we || mem_addr !== mon_e.addr ||
            (mon_e.we && (mem_wdata !== mon_e.data || mem_be !== mon_e.be))) begin
          n_fail++;
          $display("FAIL mem_txn: got we=%0b addr=%h data=%h be=%b, required we=%0b addr=%h data=%h be=%b",
                   mem_we, mem_addr, mem_wdata, mem_be, mon_e.we, mon_e.addr, mon_e.data, mon_e.be);
        end
      end
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tb_mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Drives one CPU request, pushes the expected memory traffic and load data,
  // and returns the number of stalled cycles and the data seen on release.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input bit exp_hit, input bit inv,
                       output int cycles, output logic [31:0] rdata);
    if (wr) begin
      exp_q.push_back('{1'b1, {addr[31:2], 2'b00}, wdata, be});
      if (exp_hit) exp_hits++; else exp_miss++;
    end else begin
      if (exp_hit) exp_hits++;
      else begin
        exp_miss++;
        for (int k = 0; k < LW; k++)
          exp_q.push_back('{1'b0, {addr[31:4], 4'h0} + 32'(4 * k), 32'h0, 4'h0});
      end
      rd_q.push_back(tb_mem[addr[11:2]]);
    end
    @(negedge clock);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be; inv_all = inv;
    #1;
    cycles = 0;
    while (cpu_stall === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clock);
      #1;
    end
    rdata = cpu_rdata;
    @(negedge clock);
    cpu_rd = 1'b0; cpu_wr = 1'b0; inv_all = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0; inv_all = 0;
    repeat (3) @(negedge clock);
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall: got %b, required 0", cpu_stall); end
`ifdef DCACHE_STATS_EN
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d, required 0/0", hit_count, miss_count); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_refill;
    int st; logic [31:0] rv, ev;
    do_op(1, 0, 32'h100, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5) begin n_fail++; $display("FAIL refill_stall: got %0d, required 5", st); end
    n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL refill_data: got %h, required %h", rv, ev); end
    do_op(1, 0, 32'h104, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL hit_stall: got %0d, required 0", st); end
    n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL hit_data: got %h, required %h", rv, ev); end
    do_op(1, 0, 32'h10F, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0 || rv !== ev) begin n_fail++; $display("FAIL hit_last_word: got stall %0d data %h, required 0 %h", st, rv, ev); end
  endtask

  task automatic test_store_hit;
    int st; logic [31:0] rv, ev;
    do_op(0, 1, 32'h104, 32'hAAAA5555, 4'b0011, 1, 0, st, rv);
    n_checks++; if (st !== 2) begin n_fail++; $display("FAIL store_hit_stall: got %0d, required 2", st); end
    do_op(1, 0, 32'h104, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0 || rv !== ev) begin n_fail++; $display("FAIL store_hit_readback: got stall %0d data %h, required 0 %h", st, rv, ev); end
    n_checks++; if (rv[15:0] !== 16'h5555) begin n_fail++; $display("FAIL store_hit_low_half: got %h, required 5555", rv[15:0]); end
  endtask

  task automatic test_back_to_back;
    int st; logic [31:0] rv, ev;
    do_op(1, 1, 32'h108, 32'h12345678, 4'b1111, 1, 0, st, rv);
    n_checks++; if (st !== 2) begin n_fail++; $display("FAIL rdwr_as_store_stall: got %0d, required 2", st); end
    do_op(1, 0, 32'h108, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0 || rv !== 32'h12345678 || rv !== ev) begin
      n_fail++; $display("FAIL rdwr_readback: got stall %0d data %h, required 0 12345678", st, rv); end
  endtask

  task automatic test_store_miss;
    int st; logic [31:0] rv, ev;
    do_op(0, 1, 32'h200, 32'hDEADBEEF, 4'b1001, 0, 0, st, rv);
    n_checks++; if (st !== 2) begin n_fail++; $display("FAIL store_miss_stall: got %0d, required 2", st); end
    do_op(1, 0, 32'h200, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5) begin n_fail++; $display("FAIL store_miss_no_alloc: got stall %0d, required 5", st); end
    n_checks++; if (rv !== ev) begin n_fail++; $display("FAIL store_miss_data: got %h, required %h", rv, ev); end
  endtask

  task automatic test_evict;
    int st; logic [31:0] rv, ev;
    do_op(1, 0, 32'h100, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5 || rv !== ev) begin n_fail++; $display("FAIL evict_fill_100: got stall %0d data %h, required 5 %h", st, rv, ev); end
    do_op(1, 0, 32'h500, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5 || rv !== ev) begin n_fail++; $display("FAIL evict_fill_500: got stall %0d data %h, required 5 %h", st, rv, ev); end
    do_op(1, 0, 32'h100, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5 || rv !== ev) begin n_fail++; $display("FAIL evict_refetch_100: got stall %0d data %h, required 5 %h", st, rv, ev); end
    do_op(1, 0, 32'h104, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0 || rv !== ev) begin n_fail++; $display("FAIL evict_hit_104: got stall %0d data %h, required 0 %h", st, rv, ev); end
  endtask

  task automatic test_inv_all;
    int st; logic [31:0] rv, ev;
    do_op(1, 0, 32'h100, 0, 0, 1, 1, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0 || rv !== ev) begin n_fail++; $display("FAIL inv_with_read_ignored: got stall %0d data %h, required 0 %h", st, rv, ev); end
    do_op(1, 0, 32'h100, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0) begin n_fail++; $display("FAIL inv_ignored_still_valid: got stall %0d, required 0", st); end
    @(negedge clock); inv_all = 1'b1;
    @(negedge clock); inv_all = 1'b0;
    do_op(1, 0, 32'h100, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5 || rv !== ev) begin n_fail++; $display("FAIL inv_then_miss: got stall %0d data %h, required 5 %h", st, rv, ev); end
    do_op(1, 0, 32'h10C, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 0 || rv !== ev) begin n_fail++; $display("FAIL inv_refill_hit: got stall %0d data %h, required 0 %h", st, rv, ev); end
  endtask

  task automatic test_reset_mid_refill;
    int st, cyc, base; logic [31:0] rv, ev;
    base = acc_cnt;
    gap_mode = 1'b1;
    exp_q.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
    exp_q.push_back('{1'b0, 32'h304, 32'h0, 4'h0});
    @(negedge clock);
    cpu_rd = 1'b1; cpu_addr = 32'h300;
    cyc = 0;
    while (acc_cnt < base + 2 && cyc < 100) begin @(negedge clock); #3; cyc++; end
    n_checks++; if (cyc >= 100) begin n_fail++; $display("FAIL gap_refill_timeout: got %0d words, required 2", acc_cnt - base); end
    @(negedge clock);
    reset = 1'b1; cpu_rd = 1'b0;
    @(negedge clock); #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_abandon_mem_req: got %b, required 0", mem_req); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_abandon_stall: got %b, required 0", cpu_stall); end
    reset = 1'b0; gap_mode = 1'b0;
    exp_hits = 0; exp_miss = 0;
    do_op(1, 0, 32'h300, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5 || rv !== ev) begin n_fail++; $display("FAIL partial_line_invalid: got stall %0d data %h, required 5 %h", st, rv, ev); end
    do_op(1, 0, 32'h100, 0, 0, 0, 0, st, rv); ev = rd_q.pop_front();
    n_checks++; if (st !== 5 || rv !== ev) begin n_fail++; $display("FAIL reset_read_100_miss: got stall %0d data %h, required 5 %h", st, rv, ev); end
    do_op(1, 0, 32'h104, 0, 0, 1, 0, st, rv); ev = rd_q.pop_front();
    do_op(0, 1, 32'h400, 32'h0BADF00D, 4'b1111, 0, 0, st, rv);
  endtask

  task automatic test_final;
    n_checks++; if (exp_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_expected: got %0d mem / %0d load pending, required 0/0", exp_q.size(), rd_q.size()); end
`ifdef DCACHE_STATS_EN
    n_checks++; if (hit_count !== 32'(exp_hits)) begin n_fail++; $display("FAIL stats_hits: got %0d, required %0d", hit_count, exp_hits); end
    n_checks++; if (miss_count !== 32'(exp_miss)) begin n_fail++; $display("FAIL stats_misses: got %0d, required %0d", miss_count, exp_miss); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'hC0DE_0000 | 32'(i * 4);
    test_reset;
    test_refill;
    test_store_hit;
    test_back_to_back;
    test_store_miss;
    test_evict;
    test_inv_all;
    test_reset_mid_refill;
    repeat (2) @(negedge clock);
    test_final;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
